// File: rtl/freqdiv_sched_ctrl.sv
// freqdiv_sched_ctrl: runtime-programmable multi-channel integer clock divider.
// Ratio/enable changes arrive on a valid/ready port and are applied only at the
// target channel's period boundary, so a divided clock never shows a runt pulse.
// A restarted channel can optionally be phase-aligned to channel 0.
module freqdiv_sched_ctrl #(
   parameter int NCH     = 4,
   parameter int DW      = 8,
   parameter int DEF_DIV = 2,
   localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk_in,
   input  logic           rst,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [DW-1:0]  cfg_div,
   input  logic           cfg_en,
   input  logic           cfg_align,
   output logic           cfg_done,
   output logic           cfg_err,
   output logic [NCH-1:0] div_out,
   output logic [NCH-1:0] div_tick
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_BND, S_ALIGN, S_DONE} state_t;

   state_t         state_q, state_d;

   // Latched request
   logic [CHW-1:0] req_ch_q;
   logic [DW-1:0]  req_div_q;
   logic           req_en_q;
   logic           req_align_q;
   logic           err_q;

   // Per-channel state and its next value
   logic [NCH-1:0] en_q, en_d;
   logic [NCH-1:0] hold_q, hold_d;
   logic [DW-1:0]  div_q [NCH];
   logic [DW-1:0]  div_d [NCH];
   logic [DW-1:0]  cnt_q [NCH];
   logic [DW-1:0]  cnt_d [NCH];
   logic [NCH-1:0] out_d, tick_d;

   logic           bad_req, accept, reject, apply, align_rel;
   logic           tgt_bnd, align_path;

   // Last cycle of a period: the only comparison the counters ever need.
   function automatic logic is_last(input logic [DW-1:0] cnt, input logic [DW-1:0] dv);
      return cnt == dv - DW'(1);
   endfunction

   assign bad_req    = (cfg_div < DW'(2)) || (int'(cfg_ch) >= NCH);
   assign tgt_bnd    = !en_q[req_ch_q] || is_last(cnt_q[req_ch_q], div_q[req_ch_q]);
   // Channel 0 is the phase reference, so asking it to align to itself is a plain restart.
   assign align_path = req_en_q && req_align_q && (req_ch_q != '0);

   assign cfg_ready = (state_q == S_IDLE);
   assign cfg_done  = (state_q == S_DONE);
   assign cfg_err   = err_q;

   // Sequencer state register.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Sequencer next state: accept/reject, wait for boundary, optional alignment hold.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      reject    = 1'b0;
      apply     = 1'b0;
      align_rel = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               if (bad_req) begin
                  reject = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = S_WAIT_BND;
               end
            end
         end
         S_WAIT_BND: begin
            if (tgt_bnd) begin
               apply   = 1'b1;
               state_d = align_path ? S_ALIGN : S_DONE;
            end
         end
         S_ALIGN: begin
            // div_tick[0] marks channel 0's last cycle; a stopped channel 0 gives nothing to wait for.
            if (div_tick[0] || !en_q[0]) begin
               align_rel = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Capture the accepted request and produce the one-cycle reject pulse.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         req_ch_q    <= '0;
         req_div_q   <= '0;
         req_en_q    <= 1'b0;
         req_align_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= reject;
         if (accept) begin
            req_ch_q    <= cfg_ch;
            req_div_q   <= cfg_div;
            req_en_q    <= cfg_en;
            req_align_q <= cfg_align;
         end
      end
   end

   // Channel next-state: free-running count, boundary reload, alignment hold/release,
   // and output decode from the next counter so outputs line up with the counter.
   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         en_d[c]   = en_q[c];
         div_d[c]  = div_q[c];
         hold_d[c] = 1'b0;
         if (en_q[c] && !hold_q[c])
            cnt_d[c] = is_last(cnt_q[c], div_q[c]) ? '0 : cnt_q[c] + DW'(1);
         else
            cnt_d[c] = div_q[c] - DW'(1);
         if (req_ch_q == CHW'(c)) begin
            if (apply) begin
               en_d[c]   = req_en_q;
               div_d[c]  = req_div_q;
               hold_d[c] = align_path;
               cnt_d[c]  = (req_en_q && !align_path) ? '0 : req_div_q - DW'(1);
            end else if (state_q == S_ALIGN) begin
               hold_d[c] = !align_rel;
               cnt_d[c]  = align_rel ? '0 : div_q[c] - DW'(1);
            end
         end
         out_d[c]  = en_d[c] && !hold_d[c] && (cnt_d[c] < (div_d[c] >> 1));
         tick_d[c] = en_d[c] && !hold_d[c] && is_last(cnt_d[c], div_d[c]);
      end
   end

   // Channel registers and flop-driven divided clocks/ticks.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NCH; c++) begin
            div_q[c] <= DW'(DEF_DIV);
            cnt_q[c] <= DW'(DEF_DIV - 1);
         end
         en_q     <= '0;
         hold_q   <= '0;
         div_out  <= '0;
         div_tick <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            div_q[c] <= div_d[c];
            cnt_q[c] <= cnt_d[c];
         end
         en_q     <= en_d;
         hold_q   <= hold_d;
         div_out  <= out_d;
         div_tick <= tick_d;
      end
   end

endmodule

// File: tb/tb_freqdiv_sched_ctrl.sv
// Bench for freqdiv_sched_ctrl: a timeline model predicts every cycle's outputs
// from period start times and divisors; a monitor compares them at negedge.
module tb_freqdiv_sched_ctrl;
   localparam int NCH     = 4;
   localparam int DW      = 8;
   localparam int DEF_DIV = 2;

   logic           clk_in = 1'b0;
   logic           rst = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [1:0]     cfg_ch = '0;
   logic [DW-1:0]  cfg_div = '0;
   logic           cfg_en = 1'b0;
   logic           cfg_align = 1'b0;
   logic           cfg_done;
   logic           cfg_err;
   logic [NCH-1:0] div_out;
   logic [NCH-1:0] div_tick;

   freqdiv_sched_ctrl #(.NCH(NCH), .DW(DW), .DEF_DIV(DEF_DIV)) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .cfg_align (cfg_align),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .div_out   (div_out),
      .div_tick  (div_tick)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [NCH-1:0] out;
      logic [NCH-1:0] tick;
      logic           ready;
      logic           done;
      logic           err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   // Model: a running channel's period began at m_start; its phase is elapsed cycles mod div.
   bit   m_rst;
   bit   m_en    [NCH];
   int   m_div   [NCH];
   int   m_start [NCH];
   bit   p_valid;
   bit   p_en;
   int   p_time, p_ch, p_div, p_start;
   int   busy_from, done_at, err_at;

   function automatic int phase(int c, int t);
      return (t - m_start[c]) % m_div[c];
   endfunction

   function automatic int next_last(int c, int from);
      for (int t = from; t < from + 1000; t++)
         if (t >= m_start[c] && phase(c, t) == m_div[c] - 1) return t;
      return from;
   endfunction

   function automatic exp_t model_now();
      exp_t e;
      e = '0;
      if (m_rst) begin
         e.ready = 1'b1;
         return e;
      end
      for (int c = 0; c < NCH; c++) begin
         if (m_en[c] && cyc >= m_start[c]) begin
            e.out[c]  = phase(c, cyc) < m_div[c] / 2;
            e.tick[c] = phase(c, cyc) == m_div[c] - 1;
         end
      end
      e.ready = !(cyc >= busy_from && cyc <= done_at);
      e.done  = (cyc == done_at);
      e.err   = (cyc == err_at);
      return e;
   endfunction

   task automatic model_reset();
      m_rst = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         m_en[c]    = 1'b0;
         m_div[c]   = DEF_DIV;
         m_start[c] = 0;
      end
      p_valid   = 1'b0;
      busy_from = -1;
      done_at   = -1;
      err_at    = -1;
   endtask

   // Advance one cycle, apply any scheduled channel change, queue the expected outputs.
   task automatic step();
      @(posedge clk_in);
      #1;
      cyc++;
      if (p_valid && cyc == p_time) begin
         m_en[p_ch]    = p_en;
         m_div[p_ch]   = p_div;
         m_start[p_ch] = p_start;
         p_valid       = 1'b0;
      end
      exp_q.push_back(model_now());
   endtask

   task automatic check_reset_state();
      #1;
      n_checks++;
      if (div_out !== '0 || div_tick !== '0 || cfg_ready !== 1'b1 ||
          cfg_done !== 1'b0 || cfg_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset state @cyc %0d: out=%b tick=%b ready=%b done=%b err=%b",
                  cyc, div_out, div_tick, cfg_ready, cfg_done, cfg_err);
      end
   endtask

   // Asynchronous reset mid-cycle: outputs must drop at once, so this cycle's expectation is redone.
   task automatic reset_now();
      exp_t dummy;
      rst       = 1'b0;
      cfg_valid = 1'b0;
      model_reset();
      dummy = exp_q.pop_back();
      exp_q.push_back(model_now());
      check_reset_state();
   endtask

   task automatic release_reset();
      rst   = 1'b1;
      m_rst = 1'b0;
   endtask

   // Present a request in the current cycle and predict when it lands.
   task automatic start_req(int ch, int dv, bit en, bit al);
      int a, b, r, d;
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_div   = DW'(dv);
      cfg_en    = en;
      cfg_align = al;
      a = cyc;
      if (dv < 2) begin
         err_at = a + 1;
      end else begin
         b = m_en[ch] ? next_last(ch, a + 1) : a + 1;
         p_valid = 1'b1;
         p_time  = b + 1;
         p_ch    = ch;
         p_div   = dv;
         p_en    = en;
         if (!en || !al || ch == 0) begin
            p_start = b + 1;
            d       = b + 1;
         end else begin
            r       = m_en[0] ? next_last(0, b + 1) : b + 1;
            p_start = r + 1;
            d       = r + 1;
         end
         busy_from = a + 1;
         done_at   = d;
      end
   endtask

   task automatic request(int ch, int dv, bit en, bit al);
      start_req(ch, dv, en, al);
      step();
      cfg_valid = 1'b0;
      for (int k = 0; k < 2000 && (cyc < done_at || cyc < err_at); k++) step();
      n_checks++;
      if (cyc < done_at || cyc < err_at) begin
         n_fail++;
         $display("FAIL request wait expired @cyc %0d: done_at=%0d err_at=%0d", cyc, done_at, err_at);
      end
      step();
   endtask

   task automatic wait_phase(int c, int p);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (m_en[c] && cyc >= m_start[c] && phase(c, cyc) == p) begin
            hit = 1'b1;
            break;
         end
         step();
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL wait_phase expired @cyc %0d: ch=%0d phase=%0d", cyc, c, p);
      end
   endtask

   // Monitor: compare every cycle's outputs against the queued expectation.
   always @(negedge clk_in) begin
      exp_t e;
      exp_t got;
      if (exp_q.size() > 0) begin
         e         = exp_q.pop_front();
         got.out   = div_out;
         got.tick  = div_tick;
         got.ready = cfg_ready;
         got.done  = cfg_done;
         got.err   = cfg_err;
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL outputs @cyc %0d: got out=%b tick=%b ready=%b done=%b err=%b, expected out=%b tick=%b ready=%b done=%b err=%b",
                     cyc, got.out, got.tick, got.ready, got.done, got.err,
                     e.out, e.tick, e.ready, e.done, e.err);
         end
      end
   end

   initial begin
      int ch, dv;
      bit en, al;
      model_reset();
      repeat (3) step();
      release_reset();
      repeat (2) step();

      // Enable ch0 at div 4, then retune to 3 mid-period
      request(0, 4, 1'b1, 1'b0);
      repeat (10) step();
      wait_phase(0, 1);
      request(0, 3, 1'b1, 1'b0);
      repeat (8) step();

      // Illegal divisors are rejected without side effects
      request(1, 1, 1'b1, 1'b0);
      request(1, 0, 1'b1, 1'b1);
      repeat (3) step();

      // Phase-aligned start of ch2 against ch0 at div 6
      request(0, 6, 1'b1, 1'b0);
      repeat (3) step();
      request(2, 3, 1'b1, 1'b1);
      repeat (14) step();

      // Disable ch0 mid-period with ch1 running alongside
      request(1, 2, 1'b1, 1'b0);
      request(0, 5, 1'b1, 1'b0);
      repeat (4) step();
      request(0, 5, 1'b0, 1'b0);
      repeat (12) step();

      // Identical request and align with ch0 stopped
      request(1, 2, 1'b1, 1'b0);
      request(3, 4, 1'b1, 1'b1);
      repeat (6) step();

      // Randomised requests
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 4)) step();
         ch = $urandom_range(0, NCH - 1);
         if ($urandom_range(0, 9) == 0)      dv = $urandom_range(0, 1);
         else if ($urandom_range(0, 14) == 0) dv = $urandom_range(100, 255);
         else                                 dv = $urandom_range(2, 12);
         en = ($urandom_range(0, 3) != 0);
         al = $urandom_range(0, 1);
         request(ch, dv, en, al);
      end
      repeat (10) step();

      // Reset while a request waits for its boundary
      request(3, 200, 1'b1, 1'b0);
      start_req(3, 5, 1'b1, 1'b0);
      step();
      cfg_valid = 1'b0;
      step();
      reset_now();
      repeat (3) step();
      release_reset();
      repeat (5) step();
      request(0, 4, 1'b1, 1'b0);
      repeat (6) step();

      @(negedge clk_in);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/freqdiv_sched_ctrl.md
Name: freqdiv_sched_ctrl

Overview:
- Runtime-programmable multi-channel integer clock-divider scheduler.
- Holds NCH divider channels and accepts ratio and enable changes from a valid/ready configuration port.
- Applies each change only at the target channel's period boundary, so no runt pulses occur.
- Can phase-align a restarted channel to channel 0; sits between the control/register block and the clock-enable consumers.

Parameters:
- NCH, 4, number of divider channels (2..8).
- DW, 8, divisor width; legal divisor range 2..2^DW-1.
- DEF_DIV, 2, divisor loaded into every channel at reset.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- cfg_valid  in  1  configuration request valid.
- cfg_ready  out  1  controller can accept a request.
- cfg_ch  in  clog2(NCH)  target channel.
- cfg_div  in  DW  new divisor.
- cfg_en  in  1  new channel enable.
- cfg_align  in  1  restart the channel phase-aligned to channel 0 (ignored for ch 0).
- cfg_done  out  1  one-cycle pulse when the request has taken effect.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- div_out  out  NCH  per-channel divided clock (flop-driven).
- div_tick  out  NCH  per-channel one-cycle pulse on the last cycle of each period.

Behaviour:
- Reset (async, rst=0):
  - all channels: en=0, div=DEF_DIV, counter=DEF_DIV-1.
  - div_out=0, div_tick=0, cfg_ready=1, cfg_done=0, cfg_err=0, FSM=IDLE.
- Channel counter, when enabled:
  - counts 0..div-1 and wraps to 0.
  - div_out[c]=1 exactly in cycles where counter<(div>>1); div_tick[c]=1 exactly when counter==div-1.
  - Both are registered from the next-counter decode, so they carry no added lag relative to the counter.
- Disabled channel: counter held at div-1; div_out=0; div_tick=0.
- Handshake: a transfer is cfg_valid&cfg_ready in IDLE. It latches ch/div/en/align, and cfg_ready drops the following cycle.
- Reject path: cfg_div<2 or cfg_ch>=NCH.
  - cfg_err pulses the next cycle; no state change; FSM stays IDLE.
  - cfg_ready stays 1.
- FSM IDLE -> WAIT_BND:
  - Boundary condition: target counter==div-1, or target channel disabled.
  - In the boundary cycle, the next edge loads div<=new div and en<=new en.
  - If en=0: counter<=new div-1; go to DONE.
  - If en=1 and align=0 (or ch=0): counter<=0; go to DONE.
  - If en=1 and align=1: counter<=new div-1, output held low; go to ALIGN.
- ALIGN:
  - Target held at div-1 until div_tick[0]=1.
  - On that edge the target counter goes to 0, coincident with channel 0's counter going to 0; go to DONE.
  - If channel 0 is disabled, ALIGN releases immediately (next edge) and does not align.
- DONE: cfg_done=1 for one cycle; next state IDLE with cfg_ready=1.
- Non-target channels run undisturbed throughout any reconfiguration.
- A request identical to the current setting still goes through the full sequence, including a restart at the boundary (counter<=0 or ALIGN hold).
- Arithmetic: counters are DW bits; compare against div-1 only; no overflow is possible since div<=2^DW-1.
- Reset mid-operation aborts the request; all state returns to reset values and no cfg_done is issued.

Test Plan:
- Reset, enable ch0 with div=4 -> cfg_done within 2 cycles; div_out[0] pattern 1100 repeating; div_tick[0] every 4th cycle.
- With ch0 at div=4 running, request ch0 div=3 mid-period (counter=1) -> old period completes (counter 2,3); next period is 100; cfg_done in the cycle after the switch.
- Request div=1 on ch1 -> cfg_err pulse one cycle later; ch1 state unchanged; cfg_ready stays 1.
- Ch0 at div=6; enable ch2 div=3 with align=1 -> ch2 low until ch0 wraps; afterwards ch2 counter=0 in the same cycles as ch0 counter=0; div_tick[2] every 3 cycles.
- Disable ch0 while running at div=5 -> completes the current period, then div_out[0]=0 and div_tick[0]=0 permanently; ch1 (div=2, running) is unaffected throughout.
- Assert rst during WAIT_BND -> all outputs return to reset values immediately; cfg_ready=1; no cfg_done pulse.
